// File: rtl/npc_sequencer.sv
// Next-PC select sequencer: drives the 4:1 PC mux select and handles delay slots,
// annulment, jmpl and trap flush. Optional statistics counters under NPC_SEQ_STATS_EN.
module npc_sequencer #(
    parameter int TRAP_FLUSH = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_valid,
    input  logic             branch_taken,
    input  logic             branch_always,
    input  logic             annul_bit,
    input  logic             jmpl_valid,
    input  logic             trap_req,
    output logic [1:0]       pc_sel,
    output logic             pc_en,
    output logic             annul_o,
    output logic             dcti_err,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] annul_cnt
);

    typedef enum logic [1:0] {RUN, DSLOT, ANNUL, TRAP} state_e;
    typedef enum logic [1:0] {SEL_SEQ, SEL_BR, SEL_JMPL, SEL_TRAP} sel_e;

    localparam int              FC_W       = 4;
    localparam logic [FC_W-1:0] FLUSH_INIT = FC_W'(TRAP_FLUSH - 1);

    state_e          state_q, state_d;
    logic [FC_W-1:0] flush_q, flush_d;
    logic            dcti_q, dcti_d;
    sel_e            sel;

    // NOTE: every signal driven here gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        dcti_d  = 1'b0;
        sel     = SEL_SEQ;
        if (trap_req) begin
            sel     = SEL_TRAP;
            state_d = TRAP;
            flush_d = FLUSH_INIT;
        end else if (state_q == TRAP) begin
            // The flush drains even while the pipeline is stalled.
            if (flush_q == '0) state_d = RUN;
            else               flush_d = flush_q - FC_W'(1);
        end else if (!stall) begin
            case (state_q)
                RUN: begin
                    if (jmpl_valid) begin
                        sel     = SEL_JMPL;
                        state_d = DSLOT;
                    end else if (branch_valid) begin
                        if (branch_taken) begin
                            sel     = SEL_BR;
                            state_d = (annul_bit && branch_always) ? ANNUL : DSLOT;
                        end else if (annul_bit) begin
                            state_d = ANNUL;
                        end
                    end
                end
                DSLOT: begin
                    state_d = RUN;
                    dcti_d  = branch_valid | jmpl_valid;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            flush_q <= '0;
            dcti_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            dcti_q  <= dcti_d;
        end
    end

    assign pc_sel   = sel;
    assign pc_en    = !stall || trap_req;
    assign annul_o  = (state_q == ANNUL) || (state_q == TRAP);
    assign dcti_err = dcti_q;

`ifdef NPC_SEQ_STATS_EN
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] annul_cnt_q, annul_cnt_d;

    // Both counters saturate at all-ones.
    always_comb begin
        taken_cnt_d = taken_cnt_q;
        annul_cnt_d = annul_cnt_q;
        if ((sel == SEL_BR || sel == SEL_JMPL) && !(&taken_cnt_q))
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
        if (((state_q == ANNUL && !stall) || state_q == TRAP) && !(&annul_cnt_q))
            annul_cnt_d = annul_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q <= '0;
            annul_cnt_q <= '0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            annul_cnt_q <= annul_cnt_d;
        end
    end

    assign taken_cnt = taken_cnt_q;
    assign annul_cnt = annul_cnt_q;
`else
    assign taken_cnt = '0;
    assign annul_cnt = '0;
`endif

endmodule

// File: tb/tb_npc_sequencer.sv
// Self-checking bench for npc_sequencer: directed scenarios plus randomized cycles
// compared against a behavioural model of the control-transfer rules.
module tb_npc_sequencer;

    localparam int TF    = 3;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall, branch_valid, branch_taken, branch_always, annul_bit;
    logic             jmpl_valid, trap_req;
    logic [1:0]       pc_sel;
    logic             pc_en, annul_o, dcti_err;
    logic [CNT_W-1:0] taken_cnt, annul_cnt;

    npc_sequencer #(.TRAP_FLUSH(TF), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_valid (branch_valid),
        .branch_taken (branch_taken),
        .branch_always(branch_always),
        .annul_bit    (annul_bit),
        .jmpl_valid   (jmpl_valid),
        .trap_req     (trap_req),
        .pc_sel       (pc_sel),
        .pc_en        (pc_en),
        .annul_o      (annul_o),
        .dcti_err     (dcti_err),
        .taken_cnt    (taken_cnt),
        .annul_cnt    (annul_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the next decode slot is, in plain terms.
    int flush_left;   // remaining post-trap cycles with the fetch path squashed
    bit squash_slot;  // next decode slot is annulled by a branch a-bit
    bit delay_slot;   // next decode slot is a delay slot
    bit dcti_flag;
    int m_taken, m_annul;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        flush_left  = 0;
        squash_slot = 0;
        delay_slot  = 0;
        dcti_flag   = 0;
        m_taken     = 0;
        m_annul     = 0;
    endtask

    task automatic step(input bit tr, input bit st, input bit bv, input bit bt,
                        input bit ba, input bit ab, input bit jm, input string tag);
        int exp_sel;
        bit busy;
        @(negedge clk);
        trap_req = tr; stall = st; branch_valid = bv; branch_taken = bt;
        branch_always = ba; annul_bit = ab; jmpl_valid = jm;
        #1;
        busy = (flush_left > 0) || squash_slot || delay_slot;
        if (tr)                exp_sel = 3;
        else if (st || busy)   exp_sel = 0;
        else if (jm)           exp_sel = 2;
        else if (bv && bt)     exp_sel = 1;
        else                   exp_sel = 0;

        check({tag, ".pc_sel"},   32'(pc_sel),   32'(exp_sel));
        check({tag, ".pc_en"},    32'(pc_en),    32'(!st || tr));
        check({tag, ".annul_o"},  32'(annul_o),  32'((flush_left > 0) || squash_slot));
        check({tag, ".dcti_err"}, 32'(dcti_err), 32'(dcti_flag));
`ifdef NPC_SEQ_STATS_EN
        check({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(m_taken));
        check({tag, ".annul_cnt"}, 32'(annul_cnt), 32'(m_annul));
`else
        check({tag, ".taken_cnt"}, 32'(taken_cnt), 32'd0);
        check({tag, ".annul_cnt"}, 32'(annul_cnt), 32'd0);
`endif
        // Statistics use the state at the start of this cycle.
        if ((exp_sel == 1 || exp_sel == 2) && m_taken < CMAX) m_taken++;
        if (((squash_slot && !st) || flush_left > 0) && m_annul < CMAX) m_annul++;

        dcti_flag = 0;
        if (tr) begin
            flush_left  = TF;
            squash_slot = 0;
            delay_slot  = 0;
        end else if (flush_left > 0) begin
            flush_left--;
        end else if (!st) begin
            if (squash_slot) begin
                squash_slot = 0;
            end else if (delay_slot) begin
                delay_slot = 0;
                dcti_flag  = bv || jm;
            end else if (jm) begin
                delay_slot = 1;
            end else if (bv) begin
                if (bt && ab && ba)  squash_slot = 1;
                else if (bt)         delay_slot  = 1;
                else if (ab)         squash_slot = 1;
            end
        end
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        {stall, branch_valid, branch_taken, branch_always, annul_bit, jmpl_valid, trap_req} = '0;
        model_reset();
        #12;
        check("reset.pc_sel",   32'(pc_sel),   32'd0);
        check("reset.annul_o",  32'(annul_o),  32'd0);
        check("reset.dcti_err", 32'(dcti_err), 32'd0);
        check("reset.taken",    32'(taken_cnt), 32'd0);
        check("reset.annul",    32'(annul_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Taken branch, a=0: delay slot then RUN
        step(0, 0, 1, 1, 0, 0, 0, "br_a0");
        idle("br_a0_slot");
        idle("br_a0_run");
        // BA with a=1: slot annulled
        step(0, 0, 1, 1, 1, 1, 0, "ba_a1");
        idle("ba_a1_slot");
        idle("ba_a1_run");
        // BA a=1 with the annulled slot stalled for two cycles
        step(0, 0, 1, 1, 1, 1, 0, "ba_st");
        step(0, 1, 0, 0, 0, 0, 0, "ba_st_s1");
        step(0, 1, 0, 0, 0, 0, 0, "ba_st_s2");
        idle("ba_st_adv");
        idle("ba_st_run");
        // Not taken, a=1: branch in squashed slot ignored
        step(0, 0, 1, 0, 0, 1, 0, "nt_a1");
        step(0, 0, 1, 1, 0, 0, 0, "nt_a1_slot");
        idle("nt_a1_run");
        // Not taken, a=0: stay in RUN
        step(0, 0, 1, 0, 0, 0, 0, "nt_a0");
        // jmpl then branch in delay slot -> dcti_err
        step(0, 0, 0, 0, 0, 0, 1, "jmpl");
        step(0, 0, 1, 1, 0, 0, 0, "jmpl_dcti");
        idle("dcti_pulse");
        idle("dcti_clear");
        // Trap under stall; jmpl during flush ignored
        step(1, 1, 0, 0, 0, 0, 0, "trap");
        step(0, 1, 0, 0, 0, 0, 1, "flush1");
        step(0, 0, 0, 0, 0, 0, 1, "flush2");
        step(0, 1, 1, 1, 0, 0, 0, "flush3");
        idle("flush_done");
        // Trap restarted inside the flush
        step(1, 0, 0, 0, 0, 0, 0, "trap_a");
        step(0, 0, 0, 0, 0, 0, 0, "trap_a1");
        step(1, 0, 1, 1, 0, 0, 0, "trap_b");
        repeat (4) idle("trap_b_drain");

        // Async reset mid-TRAP takes effect before any clock edge
        step(1, 0, 0, 0, 0, 0, 0, "trap_rst");
        idle("trap_rst_in");
        rst_n = 1'b0;
        #1;
        check("rst_mid.annul_o",  32'(annul_o),  32'd0);
        check("rst_mid.pc_sel",   32'(pc_sel),   32'd0);
        check("rst_mid.dcti_err", 32'(dcti_err), 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle("post_rst");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
